traffic_sensor_unit: RTL and testbench
======================================

// Module: traffic_sensor_unit
// PURPOSE
//  Front end feeding the intersection light controller's TA/TB traffic inputs.
//  Conditions raw street-A/B car-detector inputs: 2-flop sync, debounce, one arrival per clean rising edge.
//  Keeps a per-street queue of waiting cars; drains it at a fixed rate while that street's green is lit.
//  Drives TA/TB = "cars waiting"; GA/GB come back from the light controller.
// PARAMETERS
//  DEBOUNCE_CYCLES  4   consecutive synced cycles a new level must hold before it is accepted (>=2)
//  DEPART_CYCLES    8   green cycles per departing car (>=1)
//  QUEUE_W          4   queue counter width; max count = 2**QUEUE_W-1
// PORTS
//  clk         in   1        system clock, rising edge
//  rst         in   1        asynchronous, active-high reset
//  car_a_raw   in   1        street A detector, asynchronous, may bounce
//  car_b_raw   in   1        street B detector, asynchronous, may bounce
//  GA          in   1        street A green, from light controller
//  GB          in   1        street B green, from light controller
//  TA          out  1        queue_a != 0
//  TB          out  1        queue_b != 0
//  queue_a     out  QUEUE_W  cars waiting on A
//  queue_b     out  QUEUE_W  cars waiting on B
//  overflow_a  out  1        sticky: arrival dropped at full queue A
//  overflow_b  out  1        sticky: arrival dropped at full queue B
//  green_conflict out 1      sticky: GA and GB high in the same cycle
// BEHAVIOUR
//  Reset (async):
//   - All outputs 0.
//   - Sync flops, clean levels, debounce and departure counters all 0.
//  Per street X in {a,b}; the two streets are fully independent:
//  Sync: s1 <= car_x_raw; s2 <= s1.
//  Debounce:
//   - s2 == clean: cnt <= 0.
//   - else, cnt < DEBOUNCE_CYCLES-1: cnt++.
//   - else: clean <= s2, cnt <= 0.
//  Arrival: one-cycle pulse when clean updates 0->1.
//   - Raw first sampled high at edge k => queue_x changes at edge k+DEBOUNCE_CYCLES+1.
//   - High pulses shorter than DEBOUNCE_CYCLES synced cycles: ignored.
//   - Falling edges: debounced the same way, produce no event.
//  Departure: dep_cnt per street.
//   - G_X=1 and queue_x!=0: dep_cnt==DEPART_CYCLES-1 -> depart pulse, dep_cnt<=0; else dep_cnt++.
//   - Otherwise dep_cnt <= 0: partial progress discarded when green drops or queue empties.
//   - First departure on the DEPART_CYCLES-th consecutive green edge.
//  Queue update (one registered counter per street):
//   - arrival & depart: unchanged.
//   - arrival only: +1. If already at max: stays at max, overflow_x <= 1.
//   - depart only: -1. Never underflows; departure needs queue != 0.
//  GA & GB both high:
//   - green_conflict <= 1; neither street drains; both dep_cnt <= 0.
//   - Arrivals still counted.
//  Sticky flags clear only on rst.
//  TA/TB: combinational from registered queues; valid the cycle after the queue edge.
//  Reset mid-operation:
//   - Everything clears immediately.
//   - A raw input held high through reset release yields exactly one arrival after debounce.
// TESTING
//  1 rst, car_a_raw 0->1 held 10 cyc, DEBOUNCE=4 -> queue_a 0->1 at edge k+5, TA=1; queue_b=0.
//  2 car_b_raw high 3 cyc, then low -> no arrival; queue_b=0, TB=0.
//  3 queue_a=3, GA=1 steady, DEPART=8 -> queue_a 2,1,0 at green edges 8,16,24; TA=0 after; counter idle.
//  4 queue_a=15 (QUEUE_W=4), GA=0, one more arrival -> queue_a=15, overflow_a=1, stays 1 until rst.
//  5 queue_a=2, GA=1; arrival lands on the same edge as the 8th green cycle -> queue_a stays 2.
//  6 GA=GB=1 for 1 cycle, queues 2/2 -> green_conflict=1, no departures; mid-run rst -> all outputs 0.

Source files
------------

// File: rtl/traffic_sensor_unit.sv
// Car-detector front end for the intersection light controller: conditions raw
// street A/B detectors into arrivals and keeps a per-street count of waiting cars.

module traffic_sensor_street #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DEPART_CYCLES   = 8,
    parameter int QUEUE_W         = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               car_raw,
    input  logic               drain_en,
    output logic [QUEUE_W-1:0] queue,
    output logic               overflow
);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int DEP_W = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
    localparam logic [DB_W-1:0]    DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEP_W-1:0]   DEP_LAST  = DEP_W'(DEPART_CYCLES - 1);
    localparam logic [QUEUE_W-1:0] QUEUE_MAX = {QUEUE_W{1'b1}};
    localparam logic [QUEUE_W-1:0] QUEUE_NIL = {QUEUE_W{1'b0}};

    logic               sync1_r;
    logic               sync2_r;
    logic               clean_r;
    logic [DB_W-1:0]    db_cnt_r;
    logic [DEP_W-1:0]   dep_cnt_r;
    logic [QUEUE_W-1:0] queue_r;
    logic               overflow_r;
    logic               arrival_s;
    logic               depart_s;

    // Arrival fires on the edge the clean level rises; departure on the last green cycle of a slot.
    always_comb begin
        arrival_s = 1'b0;
        depart_s  = 1'b0;
        if ((sync2_r != clean_r) && (db_cnt_r == DB_LAST)) begin
            arrival_s = sync2_r;
        end else begin
            arrival_s = 1'b0;
        end
        if (drain_en && (queue_r != QUEUE_NIL) && (dep_cnt_r == DEP_LAST)) begin
            depart_s = 1'b1;
        end else begin
            depart_s = 1'b0;
        end
    end

    // Two-flop synchronizer and level debouncer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r  <= 1'b0;
            sync2_r  <= 1'b0;
            clean_r  <= 1'b0;
            db_cnt_r <= {DB_W{1'b0}};
        end else begin
            sync1_r <= car_raw;
            sync2_r <= sync1_r;
            if (sync2_r == clean_r) begin
                db_cnt_r <= {DB_W{1'b0}};
            end else if (db_cnt_r < DB_LAST) begin
                db_cnt_r <= db_cnt_r + 1'b1;
            end else begin
                clean_r  <= sync2_r;
                db_cnt_r <= {DB_W{1'b0}};
            end
        end
    end

    // Departure slot timer; any break in green or an empty queue discards progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dep_cnt_r <= {DEP_W{1'b0}};
        end else if (drain_en && (queue_r != QUEUE_NIL)) begin
            if (dep_cnt_r == DEP_LAST) begin
                dep_cnt_r <= {DEP_W{1'b0}};
            end else begin
                dep_cnt_r <= dep_cnt_r + 1'b1;
            end
        end else begin
            dep_cnt_r <= {DEP_W{1'b0}};
        end
    end

    // Waiting-car counter with saturating arrivals and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            queue_r    <= QUEUE_NIL;
            overflow_r <= 1'b0;
        end else begin
            case ({arrival_s, depart_s})
                2'b10: begin
                    if (queue_r == QUEUE_MAX) begin
                        overflow_r <= 1'b1;
                    end else begin
                        queue_r <= queue_r + 1'b1;
                    end
                end
                2'b01:   queue_r <= queue_r - 1'b1;
                default: queue_r <= queue_r;
            endcase
        end
    end

    assign queue    = queue_r;
    assign overflow = overflow_r;
endmodule

module traffic_sensor_unit #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DEPART_CYCLES   = 8,
    parameter int QUEUE_W         = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               car_a_raw,
    input  logic               car_b_raw,
    input  logic               GA,
    input  logic               GB,
    output logic               TA,
    output logic               TB,
    output logic [QUEUE_W-1:0] queue_a,
    output logic [QUEUE_W-1:0] queue_b,
    output logic               overflow_a,
    output logic               overflow_b,
    output logic               green_conflict
);
    logic drain_a_s;
    logic drain_b_s;
    logic green_conflict_r;

    // A simultaneous green on both streets is illegal, so neither street drains then.
    assign drain_a_s = GA & ~GB;
    assign drain_b_s = GB & ~GA;

    traffic_sensor_street #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .DEPART_CYCLES  (DEPART_CYCLES),
        .QUEUE_W        (QUEUE_W)
    ) u_street_a (
        .clk     (clk),
        .rst     (rst),
        .car_raw (car_a_raw),
        .drain_en(drain_a_s),
        .queue   (queue_a),
        .overflow(overflow_a)
    );

    traffic_sensor_street #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .DEPART_CYCLES  (DEPART_CYCLES),
        .QUEUE_W        (QUEUE_W)
    ) u_street_b (
        .clk     (clk),
        .rst     (rst),
        .car_raw (car_b_raw),
        .drain_en(drain_b_s),
        .queue   (queue_b),
        .overflow(overflow_b)
    );

    // Sticky record of any cycle with both greens lit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            green_conflict_r <= 1'b0;
        end else if (GA && GB) begin
            green_conflict_r <= 1'b1;
        end else begin
            green_conflict_r <= green_conflict_r;
        end
    end

    assign green_conflict = green_conflict_r;
    assign TA = (queue_a != {QUEUE_W{1'b0}});
    assign TB = (queue_b != {QUEUE_W{1'b0}});
endmodule

// File: tb/tb_traffic_sensor_unit.sv
// Bench for traffic_sensor_unit: directed scenarios plus randomized traffic
// checked against a sample-history reference model.

module tb_traffic_sensor_unit;
    localparam int D  = 4;
    localparam int P  = 8;
    localparam int QW = 4;
    localparam int QMAX = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          car_a_raw;
    logic          car_b_raw;
    logic          GA;
    logic          GB;
    logic          TA;
    logic          TB;
    logic [QW-1:0] queue_a;
    logic [QW-1:0] queue_b;
    logic          overflow_a;
    logic          overflow_b;
    logic          green_conflict;

    int checks = 0;
    int errors = 0;

    // Reference model state: raw/synced sample histories, accepted levels, green streaks, queues.
    logic [15:0] m_raw_h [2];
    logic [15:0] m_syn_h [2];
    logic        m_acc   [2];
    int          m_streak[2];
    int          m_q     [2];
    logic        m_ovf   [2];
    logic        m_conf;

    logic [12:0] dut_vec;
    assign dut_vec = {TA, TB, queue_a, queue_b, overflow_a, overflow_b, green_conflict};

    traffic_sensor_unit #(.DEBOUNCE_CYCLES(D), .DEPART_CYCLES(P), .QUEUE_W(QW)) dut (
        .clk           (clk),
        .rst           (rst),
        .car_a_raw     (car_a_raw),
        .car_b_raw     (car_b_raw),
        .GA            (GA),
        .GB            (GB),
        .TA            (TA),
        .TB            (TB),
        .queue_a       (queue_a),
        .queue_b       (queue_b),
        .overflow_a    (overflow_a),
        .overflow_b    (overflow_b),
        .green_conflict(green_conflict)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] model_vec();
        return {m_q[0] != 0, m_q[1] != 0, QW'(m_q[0]), QW'(m_q[1]), m_ovf[0], m_ovf[1], m_conf};
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_raw_h[s]  = 16'd0;
            m_syn_h[s]  = 16'd0;
            m_acc[s]    = 1'b0;
            m_streak[s] = 0;
            m_q[s]      = 0;
            m_ovf[s]    = 1'b0;
        end
        m_conf = 1'b0;
    endtask

    // A level is accepted once the last D synced samples all disagree with the current one.
    task automatic model_edge();
        logic        raw_v [2];
        logic        g_v   [2];
        logic        conflict;
        logic [15:0] mask;
        int          arr;
        int          dep;
        int          n;
        raw_v[0] = car_a_raw;
        raw_v[1] = car_b_raw;
        g_v[0]   = GA;
        g_v[1]   = GB;
        conflict = GA && GB;
        mask     = (16'd1 << D) - 16'd1;
        for (int s = 0; s < 2; s++) begin
            arr = 0;
            dep = 0;
            m_raw_h[s] = {m_raw_h[s][14:0], raw_v[s]};
            m_syn_h[s] = {m_syn_h[s][14:0], m_raw_h[s][2]};
            if ((m_syn_h[s] & mask) == (m_acc[s] ? 16'd0 : mask)) begin
                m_acc[s] = ~m_acc[s];
                arr = m_acc[s] ? 1 : 0;
            end
            if (g_v[s] && !conflict && m_q[s] != 0) begin
                m_streak[s]++;
                if (m_streak[s] % P == 0) dep = 1;
            end else begin
                m_streak[s] = 0;
            end
            n = m_q[s] + arr - dep;
            if (n > QMAX) begin
                n = QMAX;
                m_ovf[s] = 1'b1;
            end
            m_q[s] = n;
        end
        if (conflict) m_conf = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (dut_vec !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", dut_vec, 13'd0);
        end
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic arrive(input logic a, input logic b);
        car_a_raw = a;
        car_b_raw = b;
        repeat (6) step();
        car_a_raw = 1'b0;
        car_b_raw = 1'b0;
        repeat (6) step();
    endtask

    task automatic test_reset();
        car_a_raw = 1'b0;
        car_b_raw = 1'b0;
        GA = 1'b0;
        GB = 1'b0;
        apply_reset();
    endtask

    task automatic test_arrival();
        apply_reset();
        car_a_raw = 1'b1;
        for (int e = 0; e < 10; e++) begin
            step();
            checks++;
            if ({TA, queue_a, TB, queue_b} !== {e >= 5, QW'(e >= 5 ? 1 : 0), 1'b0, 4'd0}) begin
                errors++;
                $display("FAIL arrival_latency edge k+%0d: got TA=%b qa=%0d TB=%b qb=%0d expected qa=%0d qb=0",
                         e, TA, queue_a, TB, queue_b, (e >= 5 ? 1 : 0));
            end
        end
        car_a_raw = 1'b0;
        repeat (6) step();
    endtask

    task automatic test_glitch();
        logic bounce [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        car_b_raw = 1'b1;
        repeat (3) step();
        car_b_raw = 1'b0;
        for (int e = 0; e < 10; e++) begin
            step();
            checks++;
            if ({TB, queue_b} !== 5'd0) begin
                errors++;
                $display("FAIL short_pulse_ignored: got TB=%b qb=%0d expected TB=0 qb=0", TB, queue_b);
            end
        end
        for (int i = 0; i < 6; i++) begin
            car_b_raw = bounce[i];
            step();
        end
        repeat (8) step();
        checks++;
        if ({TB, queue_b, queue_a} !== {1'b1, 4'd1, 4'd1}) begin
            errors++;
            $display("FAIL bounce_single_arrival: got TB=%b qb=%0d qa=%0d expected TB=1 qb=1 qa=1",
                     TB, queue_b, queue_a);
        end
        car_b_raw = 1'b0;
        repeat (6) step();
    endtask

    task automatic test_depart();
        apply_reset();
        repeat (3) arrive(1'b1, 1'b0);
        GA = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            step();
            checks++;
            if ({TA, queue_a} !== {n < 24, QW'(n >= 24 ? 0 : 3 - n / 8)}) begin
                errors++;
                $display("FAIL depart_rate green edge %0d: got TA=%b qa=%0d expected qa=%0d",
                         n, TA, queue_a, (n >= 24 ? 0 : 3 - n / 8));
            end
        end
        car_a_raw = 1'b1;
        repeat (6) step();
        for (int j = 1; j <= 8; j++) begin
            step();
            checks++;
            if (queue_a !== QW'(j < 8 ? 1 : 0)) begin
                errors++;
                $display("FAIL depart_counter_idle green edge %0d: got qa=%0d expected %0d",
                         j, queue_a, (j < 8 ? 1 : 0));
            end
        end
        car_a_raw = 1'b0;
        GA = 1'b0;
        repeat (6) step();
    endtask

    task automatic test_overflow();
        apply_reset();
        repeat (15) arrive(1'b1, 1'b0);
        checks++;
        if ({queue_a, overflow_a} !== {4'd15, 1'b0}) begin
            errors++;
            $display("FAIL fill_to_max: got qa=%0d ovf=%b expected qa=15 ovf=0", queue_a, overflow_a);
        end
        arrive(1'b1, 1'b0);
        checks++;
        if ({queue_a, overflow_a} !== {4'd15, 1'b1}) begin
            errors++;
            $display("FAIL overflow_set: got qa=%0d ovf=%b expected qa=15 ovf=1", queue_a, overflow_a);
        end
        GA = 1'b1;
        repeat (16) step();
        GA = 1'b0;
        checks++;
        if ({queue_a, overflow_a} !== {4'd13, 1'b1}) begin
            errors++;
            $display("FAIL overflow_sticky: got qa=%0d ovf=%b expected qa=13 ovf=1", queue_a, overflow_a);
        end
    endtask

    task automatic test_same_edge();
        apply_reset();
        repeat (2) arrive(1'b1, 1'b0);
        GA = 1'b1;
        repeat (2) step();
        car_a_raw = 1'b1;
        for (int e = 0; e < 14; e++) begin
            step();
            checks++;
            if (queue_a !== QW'(e == 13 ? 1 : 2)) begin
                errors++;
                $display("FAIL arrive_and_depart green edge %0d: got qa=%0d expected %0d",
                         e + 3, queue_a, (e == 13 ? 1 : 2));
            end
        end
        car_a_raw = 1'b0;
        GA = 1'b0;
        repeat (6) step();
    endtask

    task automatic test_conflict();
        apply_reset();
        repeat (2) arrive(1'b1, 1'b1);
        GA = 1'b1;
        repeat (5) step();
        GB = 1'b1;
        step();
        GB = 1'b0;
        checks++;
        if ({queue_a, queue_b, green_conflict} !== {4'd2, 4'd2, 1'b1}) begin
            errors++;
            $display("FAIL conflict_flag: got qa=%0d qb=%0d gc=%b expected 2 2 1", queue_a, queue_b, green_conflict);
        end
        for (int j = 1; j <= 8; j++) begin
            step();
            checks++;
            if ({queue_a, queue_b, green_conflict} !== {QW'(j < 8 ? 2 : 1), 4'd2, 1'b1}) begin
                errors++;
                $display("FAIL conflict_restart green edge %0d: got qa=%0d qb=%0d gc=%b expected qa=%0d",
                         j, queue_a, queue_b, green_conflict, (j < 8 ? 2 : 1));
            end
        end
        #2;
        car_a_raw = 1'b1;
        apply_reset();
        GA = 1'b0;
        repeat (8) step();
        checks++;
        if ({TA, queue_a, green_conflict} !== {1'b1, 4'd1, 1'b0}) begin
            errors++;
            $display("FAIL held_through_reset: got TA=%b qa=%0d gc=%b expected 1 1 0", TA, queue_a, green_conflict);
        end
        repeat (10) step();
        checks++;
        if (queue_a !== 4'd1) begin
            errors++;
            $display("FAIL held_single_arrival: got qa=%0d expected 1", queue_a);
        end
        car_a_raw = 1'b0;
        repeat (6) step();
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) car_a_raw = ~car_a_raw;
            if ($urandom_range(0, 5) == 0) car_b_raw = ~car_b_raw;
            if ($urandom_range(0, 19) == 0) GA = ~GA;
            if ($urandom_range(0, 19) == 0) GB = ~GB;
            if ($urandom_range(0, 599) == 0) begin
                #($urandom_range(1, 3));
                apply_reset();
            end else begin
                step();
                checks++;
                if (dut_vec !== model_vec()) begin
                    errors++;
                    $display("FAIL random_vs_model cycle %0d: got %h expected %h", i, dut_vec, model_vec());
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_arrival();
        test_glitch();
        test_depart();
        test_overflow();
        test_same_edge();
        test_conflict();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
